// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: FSM states, queue entry layout, default sizes.
package fetch_pkg;

  localparam int DEFAULT_QUEUE_DEPTH = 4;
  localparam int FETCH_ADDR_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    ARG  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [15:0]                 opcode;
    logic [15:0]                 arg;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched instructions; head is read straight from storage (zero latency).
// A push into a full queue is accepted only alongside a pop; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [4:0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == 5'(DEPTH));
  assign empty   = (count == 5'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= 5'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= 5'd0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= entry;
        tail_ptr      <= tail_ptr + PW'(1);
      end
      if (do_pop) head_ptr <= head_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + 5'd1;
      else if (do_pop && !do_push) count <= count - 5'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetches opcode/argument word pairs from blockram into an in-order queue; 2 cycles load-to-valid.
// Stalls in ARG with the address held while the queue is full; pc_load flushes and redirects.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
  parameter int ADDR_WIDTH  = FETCH_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [15:0]           read_value,
  output logic                  instr_valid,
  output logic [15:0]           instr_opcode,
  output logic [15:0]           instr_arg,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic [4:0]            queue_length
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [15:0]           pending_opcode;
  fetch_entry_t          push_entry;
  fetch_entry_t          head;
  logic                  q_full;
  logic                  q_empty;
  logic                  pop;
  logic                  push_ok;
  logic                  push;

  assign pop     = instr_valid && instr_ready;
  assign push_ok = !q_full || pop;
  assign push    = (state == ARG) && push_ok && !pc_load;

  assign push_entry.opcode = pending_opcode;
  assign push_entry.arg    = read_value;
  assign push_entry.pc     = pc;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (pc_load),
    .entry (push_entry),
    .head  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (queue_length)
  );

  assign instr_valid  = !q_empty;
  assign instr_opcode = head.opcode;
  assign instr_arg    = head.arg;
  assign instr_pc     = head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= '0;
      read_address   <= '0;
      pending_opcode <= 16'd0;
    end else if (pc_load) begin
      pc           <= pc_value;
      read_address <= pc_value;
      state        <= OP;
    end else begin
      case (state)
        OP: begin
          pending_opcode <= read_value;
          read_address   <= pc + ADDR_WIDTH'(1);
          state          <= ARG;
        end
        ARG: begin
          // Without room the address stays put so the argument is re-read on resume.
          if (push_ok) begin
            pc           <= pc + ADDR_WIDTH'(2);
            read_address <= pc + ADDR_WIDTH'(2);
            state        <= OP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural blockram and hand-computed expectations.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_load = 1'b0;
  logic [15:0] pc_value = 16'd0;
  logic [15:0] read_address;
  logic [15:0] read_value;
  logic        instr_valid;
  logic [15:0] instr_opcode;
  logic [15:0] instr_arg;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [4:0]  queue_length;

  logic [15:0] ram [65536];
  int checks = 0;
  int failures = 0;

  assign read_value = ram[read_address];

  always #5 clk = ~clk;

  instruction_fetch #(.QUEUE_DEPTH(4), .ADDR_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_load      (pc_load),
    .pc_value     (pc_value),
    .read_address (read_address),
    .read_value   (read_value),
    .instr_valid  (instr_valid),
    .instr_opcode (instr_opcode),
    .instr_arg    (instr_arg),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .queue_length (queue_length)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (read_address !== 16'd0) begin failures++; $display("FAIL reset_ra cyc%0d got=%h exp=0000", i, read_address); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc%0d got=%b exp=0", i, instr_valid); end
      checks++; if (queue_length !== 5'd0) begin failures++; $display("FAIL reset_qlen cyc%0d got=%0d exp=0", i, queue_length); end
    end
    checks++; if ({instr_opcode, instr_arg, instr_pc} !== 48'd0) begin failures++; $display("FAIL reset_head got=%h/%h/%h exp=0/0/0", instr_opcode, instr_arg, instr_pc); end
  endtask

  task automatic test_basic();
    instr_ready = 1'b1;
    pc_load = 1'b1; pc_value = 16'd50;
    tick();
    pc_load = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_n got=%b exp=0", instr_valid); end
    checks++; if (read_address !== 16'd50) begin failures++; $display("FAIL basic_ra_n got=%0d exp=50", read_address); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_n1 got=%b exp=0", instr_valid); end
    checks++; if (read_address !== 16'd51) begin failures++; $display("FAIL basic_ra_n1 got=%0d exp=51", read_address); end
    tick();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_n2 got=%b exp=1", instr_valid); end
    checks++; if ({instr_opcode, instr_arg, instr_pc} !== {16'h1210, 16'h0A35, 16'd50})
      begin failures++; $display("FAIL basic_head1 got=%h/%h/%0d exp=1210/0a35/50", instr_opcode, instr_arg, instr_pc); end
    checks++; if (queue_length !== 5'd1) begin failures++; $display("FAIL basic_qlen got=%0d exp=1", queue_length); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_popped got=%b exp=0", instr_valid); end
    tick();
    checks++; if ({instr_valid, instr_opcode, instr_arg, instr_pc} !== {1'b1, 16'h0E10, 16'h0122, 16'd52})
      begin failures++; $display("FAIL basic_head2 got=%b/%h/%h/%0d exp=1/0e10/0122/52", instr_valid, instr_opcode, instr_arg, instr_pc); end
  endtask

  task automatic test_fill_and_resume();
    logic [15:0] p;
    instr_ready = 1'b0;
    pc_load = 1'b1; pc_value = 16'd50;
    tick();
    pc_load = 1'b0;
    repeat (7) tick();
    checks++; if (queue_length !== 5'd3) begin failures++; $display("FAIL fill_qlen7 got=%0d exp=3", queue_length); end
    tick();
    checks++; if (queue_length !== 5'd4) begin failures++; $display("FAIL fill_qlen8 got=%0d exp=4", queue_length); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (read_address !== 16'd59) begin failures++; $display("FAIL fill_frozen_ra cyc%0d got=%0d exp=59", i, read_address); end
      checks++; if (queue_length !== 5'd4) begin failures++; $display("FAIL fill_frozen_qlen cyc%0d got=%0d exp=4", i, queue_length); end
    end
    checks++; if ({instr_opcode, instr_pc} !== {16'h1210, 16'd50}) begin failures++; $display("FAIL fill_head got=%h/%0d exp=1210/50", instr_opcode, instr_pc); end
    instr_ready = 1'b1;
    tick();
    checks++; if (queue_length !== 5'd4) begin failures++; $display("FAIL resume_qlen got=%0d exp=4", queue_length); end
    checks++; if (read_address !== 16'd60) begin failures++; $display("FAIL resume_ra got=%0d exp=60", read_address); end
    checks++; if ({instr_opcode, instr_arg, instr_pc} !== {16'h0E10, 16'h0122, 16'd52})
      begin failures++; $display("FAIL resume_head got=%h/%h/%0d exp=0e10/0122/52", instr_opcode, instr_arg, instr_pc); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      p = 16'(52 + 2 * k);
      checks++; if ({instr_valid, instr_opcode, instr_arg, instr_pc} !== {1'b1, ram[p], ram[p + 16'd1], p})
        begin failures++; $display("FAIL order_k%0d got=%b/%h/%h/%0d exp=1/%h/%h/%0d", k, instr_valid, instr_opcode, instr_arg, instr_pc, ram[p], ram[p + 16'd1], p); end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_flush();
    instr_ready = 1'b0;
    pc_load = 1'b1; pc_value = 16'd50;
    tick();
    pc_load = 1'b0;
    repeat (7) tick();
    checks++; if (queue_length !== 5'd3) begin failures++; $display("FAIL flush_pre_qlen got=%0d exp=3", queue_length); end
    checks++; if (read_address !== 16'd57) begin failures++; $display("FAIL flush_pre_ra got=%0d exp=57", read_address); end
    instr_ready = 1'b1;
    pc_load = 1'b1; pc_value = 16'd100;
    tick();
    pc_load = 1'b0;
    checks++; if ({instr_valid, queue_length} !== {1'b0, 5'd0}) begin failures++; $display("FAIL flush_empty got=%b/%0d exp=0/0", instr_valid, queue_length); end
    checks++; if (read_address !== 16'd100) begin failures++; $display("FAIL flush_ra got=%0d exp=100", read_address); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL flush_valid_n1 got=%b exp=0", instr_valid); end
    tick();
    checks++; if ({instr_valid, instr_opcode, instr_arg, instr_pc} !== {1'b1, ram[100], ram[101], 16'd100})
      begin failures++; $display("FAIL flush_head got=%b/%h/%h/%0d exp=1/%h/%h/100", instr_valid, instr_opcode, instr_arg, instr_pc, ram[100], ram[101]); end
    checks++; if (queue_length !== 5'd1) begin failures++; $display("FAIL flush_qlen got=%0d exp=1", queue_length); end
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    instr_ready = 1'b1;
    pc_load = 1'b1; pc_value = 16'hFFFE;
    tick();
    pc_load = 1'b0;
    checks++; if (read_address !== 16'hFFFE) begin failures++; $display("FAIL wrap_ra0 got=%h exp=fffe", read_address); end
    tick();
    checks++; if (read_address !== 16'hFFFF) begin failures++; $display("FAIL wrap_ra1 got=%h exp=ffff", read_address); end
    tick();
    checks++; if ({instr_valid, instr_opcode, instr_arg, instr_pc} !== {1'b1, ram[16'hFFFE], ram[16'hFFFF], 16'hFFFE})
      begin failures++; $display("FAIL wrap_head1 got=%b/%h/%h/%h exp=1/%h/%h/fffe", instr_valid, instr_opcode, instr_arg, instr_pc, ram[16'hFFFE], ram[16'hFFFF]); end
    checks++; if (read_address !== 16'h0000) begin failures++; $display("FAIL wrap_ra2 got=%h exp=0000", read_address); end
    tick();
    tick();
    checks++; if ({instr_valid, instr_opcode, instr_arg, instr_pc} !== {1'b1, ram[0], ram[1], 16'h0000})
      begin failures++; $display("FAIL wrap_head2 got=%b/%h/%h/%h exp=1/%h/%h/0000", instr_valid, instr_opcode, instr_arg, instr_pc, ram[0], ram[1]); end
    instr_ready = 1'b0;
    tick();
    checks++; if ({instr_valid, queue_length} !== {1'b1, 5'd1}) begin failures++; $display("FAIL prerst got=%b/%0d exp=1/1", instr_valid, queue_length); end
    rst = 1'b1;
    pc_load = 1'b1; pc_value = 16'h1234;
    instr_ready = 1'b1;
    tick();
    checks++; if ({read_address, instr_valid, queue_length} !== {16'd0, 1'b0, 5'd0})
      begin failures++; $display("FAIL rst_ctrl got=%h/%b/%0d exp=0000/0/0", read_address, instr_valid, queue_length); end
    checks++; if ({instr_opcode, instr_arg, instr_pc} !== 48'd0) begin failures++; $display("FAIL rst_head got=%h/%h/%h exp=0/0/0", instr_opcode, instr_arg, instr_pc); end
    rst = 1'b0;
    pc_load = 1'b0;
    repeat (3) tick();
    checks++; if ({read_address, instr_valid} !== {16'd0, 1'b0}) begin failures++; $display("FAIL rst_idle got=%h/%b exp=0000/0", read_address, instr_valid); end
    instr_ready = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'(a) ^ 16'hC3A5;
    ram[50] = 16'h1210;
    ram[51] = 16'h0A35;
    ram[52] = 16'h0E10;
    ram[53] = 16'h0122;
    test_reset();
    test_basic();
    test_fill_and_resume();
    test_flush();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
